// File: rtl/tft_video_pkg.sv
// Shared definitions for the TFT video receive path: RGB565 colours,
// panel defaults, receiver FSM encoding and the registered input sample.
package tft_video_pkg;

  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] PURPLE = 16'hF81F;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] CYAN   = 16'h07FF;
  localparam logic [15:0] YELLOW = 16'hFFE0;
  localparam logic [15:0] WHITE  = 16'hFFFF;

  localparam int PANEL_H_ACTIVE = 480;
  localparam int PANEL_V_ACTIVE = 272;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LINE = 2'd1,
    ST_IN_LINE   = 2'd2
  } rx_state_t;

  // hs/vs are stored already normalised to active-high
  typedef struct packed {
    logic [15:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } tft_sample_t;

endpackage

// File: rtl/tft_sync_edge.sv
// Two-stage input register with sync polarity normalisation; edge flags are
// registered so they line up with the stage-2 sample handed to the FSM.
module tft_sync_edge
  import tft_video_pkg::*;
#(
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rgb_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  output logic [15:0] rgb,
  output logic        de,
  output logic        de_next,
  output logic        de_rise,
  output logic        de_fall,
  output logic        vs_rise,
  output logic        hs_edge
);

  tft_sample_t s1, s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      de_rise <= 1'b0;
      de_fall <= 1'b0;
      vs_rise <= 1'b0;
      hs_edge <= 1'b0;
    end else begin
      s1.rgb  <= rgb_in;
      s1.hs   <= hs_in ^ SYNC_ACTIVE_LOW;
      s1.vs   <= vs_in ^ SYNC_ACTIVE_LOW;
      s1.de   <= de_in;
      s2      <= s1;
      de_rise <= s1.de & ~s2.de;
      de_fall <= ~s1.de & s2.de;
      vs_rise <= s1.vs & ~s2.vs;
      hs_edge <= s1.hs ^ s2.hs;
    end
  end

  assign rgb     = s2.rgb;
  assign de      = s2.de;
  // stage 1 is one sample ahead of the FSM, used to mark end of line
  assign de_next = s1.de;

endmodule

// File: rtl/tft_video_rx.sv
// TFT RGB565 receiver: recovers pixel coordinates from VS/DE, emits a marked
// pixel stream and reports per-frame width/height measurements and errors.
module tft_video_rx
  import tft_video_pkg::*;
#(
  parameter int H_ACTIVE        = PANEL_H_ACTIVE,
  parameter int V_ACTIVE        = PANEL_V_ACTIVE,
  parameter int XW              = 10,
  parameter int YW              = 10,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [15:0]   TFT_RGB,
  input  logic          TFT_HS,
  input  logic          TFT_VS,
  input  logic          TFT_DE,
  output logic          pix_valid,
  output logic [15:0]   pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_sof,
  output logic          pix_eol,
  output logic          frame_done,
  output logic [XW-1:0] meas_width,
  output logic [YW-1:0] meas_height,
  output logic          err_width,
  output logic          err_height,
  output logic [15:0]   frame_cnt
);

  localparam logic [XW-1:0] X_MAX = '1;
  localparam logic [YW-1:0] Y_MAX = '1;
  localparam logic [XW-1:0] H_EXP = XW'(H_ACTIVE);
  localparam logic [YW-1:0] V_EXP = YW'(V_ACTIVE);

  logic [15:0] rgb;
  logic        de, de_next, de_rise, de_fall, vs_rise, hs_edge;

  tft_sync_edge #(.SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_sync (
    .clk     (Clk),
    .rst     (Rst),
    .rgb_in  (TFT_RGB),
    .hs_in   (TFT_HS),
    .vs_in   (TFT_VS),
    .de_in   (TFT_DE),
    .rgb     (rgb),
    .de      (de),
    .de_next (de_next),
    .de_rise (de_rise),
    .de_fall (de_fall),
    .vs_rise (vs_rise),
    .hs_edge (hs_edge)
  );

  rx_state_t     state;
  logic [XW-1:0] x, px_x;
  logic [YW-1:0] y, y_cl, px_y;
  logic          w_bad, wb_cl;
  logic          line_close, frame_end, start_px, emit, px_bad;

  // A VS edge closes any open line first, so the frame report sees the
  // post-close line count and width flag (y_cl / wb_cl).
  always_comb begin
    line_close = (state == ST_IN_LINE) && (de_fall || vs_rise);
    frame_end  = vs_rise && (state != ST_IDLE);
    start_px   = de_rise && ((state == ST_WAIT_LINE) || (state == ST_IDLE && vs_rise));
    emit       = start_px || ((state == ST_IN_LINE) && de && !line_close);
    y_cl       = y;
    if (line_close && y != Y_MAX) y_cl = y + 1'b1;
    wb_cl      = w_bad | (line_close && x != H_EXP);
    px_x       = start_px ? '0 : x;
    px_y       = vs_rise ? '0 : y;
    px_bad     = emit && (px_x == X_MAX || hs_edge);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= ST_IDLE;
      x           <= '0;
      y           <= '0;
      w_bad       <= 1'b0;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      frame_done  <= 1'b0;
      meas_width  <= '0;
      meas_height <= '0;
      err_width   <= 1'b0;
      err_height  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      pix_valid  <= emit;
      pix_sof    <= emit && px_x == '0 && px_y == '0;
      pix_eol    <= emit && !de_next;
      frame_done <= frame_end;
      if (emit) begin
        pix_data <= rgb;
        pix_x    <= px_x;
        pix_y    <= px_y;
        x        <= (px_x == X_MAX) ? X_MAX : px_x + 1'b1;
      end
      if (line_close) meas_width <= x;
      if (frame_end) begin
        meas_height <= y_cl;
        err_height  <= (y_cl != V_EXP);
        err_width   <= wb_cl;
        frame_cnt   <= frame_cnt + 1'b1;
      end
      y     <= vs_rise ? '0 : y_cl;
      w_bad <= (vs_rise ? 1'b0 : wb_cl) | px_bad;
      case (state)
        ST_IDLE: begin
          if (start_px)     state <= ST_IN_LINE;
          else if (vs_rise) state <= ST_WAIT_LINE;
        end
        ST_WAIT_LINE: if (start_px)   state <= ST_IN_LINE;
        ST_IN_LINE:   if (line_close) state <= ST_WAIT_LINE;
        default:      state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tft_video_rx.sv
// Directed + randomised bench for tft_video_rx on a small panel; expected
// pixels and frame reports are derived per line/frame from what is driven.
module tb_tft_video_rx;
  import tft_video_pkg::*;

  localparam int H = 16, V = 8, XW = 6, YW = 5;
  localparam int XMAX = (1 << XW) - 1, YMAX = (1 << YW) - 1;
  localparam int OW = 38 + 2 * XW + 2 * YW;

  logic          Clk = 1'b0, Rst = 1'b1;
  logic [15:0]   TFT_RGB = '0;
  logic          TFT_HS = 1'b1, TFT_VS = 1'b1, TFT_DE = 1'b0;
  logic          pix_valid, pix_sof, pix_eol, frame_done, err_width, err_height;
  logic [15:0]   pix_data, frame_cnt;
  logic [XW-1:0] pix_x, meas_width;
  logic [YW-1:0] pix_y, meas_height;
  logic [OW-1:0] all_out;

  tft_video_rx #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .SYNC_ACTIVE_LOW(1'b1)) dut (
    .Clk(Clk), .Rst(Rst), .TFT_RGB(TFT_RGB), .TFT_HS(TFT_HS), .TFT_VS(TFT_VS), .TFT_DE(TFT_DE),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done),
    .meas_width(meas_width), .meas_height(meas_height),
    .err_width(err_width), .err_height(err_height), .frame_cnt(frame_cnt)
  );

  always #5 Clk = ~Clk;

  assign all_out = {pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, frame_done,
                    meas_width, meas_height, err_width, err_height, frame_cnt};

  typedef struct packed {
    logic [15:0] d; logic [XW-1:0] x; logic [YW-1:0] y; logic sof; logic eol;
  } px_t;
  typedef struct packed {
    logic [XW-1:0] w; logic [YW-1:0] h; logic ew; logic eh; logic [15:0] cnt;
  } rp_t;

  px_t exp_q[$];
  rp_t rpt_q[$];
  int  n_cmp = 0, n_err = 0, n_pix = 0, n_fd = 0;

  // model of the receiver at line/frame granularity
  bit  armed = 1'b0, wbad = 1'b0;
  int  m_y = 0, m_cnt = 0, last_w = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // 2 columns x 4 rows of colour bars
  function automatic logic [15:0] bar_col(input int px, input int py);
    logic [15:0] tbl [8] = '{BLACK, BLUE, RED, PURPLE, GREEN, CYAN, YELLOW, WHITE};
    return tbl[(py * 4 / V) * 2 + (px * 2 / H)];
  endfunction

  task automatic close_line(input int n);
    last_w = imin(n, XMAX);
    if (last_w != H) wbad = 1'b1;
    m_y = imin(m_y + 1, YMAX);
  endtask

  task automatic end_frame();
    rp_t r;
    if (armed) begin
      m_cnt++;
      r = {XW'(last_w), YW'(m_y), wbad, (m_y != V), 16'(m_cnt)};
      rpt_q.push_back(r);
    end
    armed = 1'b1;
    m_y   = 0;
    wbad  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    n_cmp++;
    assert (all_out === '0) else begin
      n_err++;
      $error("FAIL %s: outputs=%h required 0", tag, all_out);
    end
  endtask

  task automatic monitor();
    px_t g, e;
    rp_t gr, er;
    forever begin
      @(negedge Clk);
      if (pix_valid) begin
        n_pix++;
        g = {pix_data, pix_x, pix_y, pix_sof, pix_eol};
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL pix_unexpected: got x=%0d y=%0d, required no pixel", pix_x, pix_y);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_cmp++;
          assert (g === e) else begin
            n_err++;
            $error("FAIL pixel: got d=%h x=%0d y=%0d sof=%0b eol=%0b, required d=%h x=%0d y=%0d sof=%0b eol=%0b",
                   g.d, g.x, g.y, g.sof, g.eol, e.d, e.x, e.y, e.sof, e.eol);
          end
        end
      end
      if (frame_done) begin
        n_fd++;
        gr = {meas_width, meas_height, err_width, err_height, frame_cnt};
        n_cmp++;
        assert (rpt_q.size() != 0) else begin
          n_err++;
          $error("FAIL frame_unexpected: got frame_done cnt=%0d, required none", frame_cnt);
        end
        if (rpt_q.size() != 0) begin
          er = rpt_q.pop_front();
          n_cmp++;
          assert (gr === er) else begin
            n_err++;
            $error("FAIL frame_rpt: got w=%0d h=%0d ew=%0b eh=%0b cnt=%0d, required w=%0d h=%0d ew=%0b eh=%0b cnt=%0d",
                   gr.w, gr.h, gr.ew, gr.eh, gr.cnt, er.w, er.h, er.ew, er.eh, er.cnt);
          end
        end
      end
    end
  endtask

  // One DE burst of len cycles plus a 5-cycle blank with an HS pulse.
  // vs_at: VS asserted at that sample; hs_at: HS glitch inside DE;
  // rst_at: one-cycle reset at that sample (must be >= 2 and < len-1).
  task automatic line(input int len, input int vs_at = -1, input int hs_at = -1,
                      input int rst_at = -1, input bit bars = 1'b0);
    bit          act = armed;
    logic [15:0] c;
    int          xi;
    px_t         p;
    for (int i = 0; i < len; i++) begin
      @(negedge Clk);
      if (rst_at >= 0 && i == rst_at + 1) check_zero("rst_mid");
      c       = bars ? bar_col(i, m_y) : 16'($urandom);
      TFT_DE  = 1'b1;
      TFT_RGB = c;
      TFT_HS  = !(hs_at >= 0 && i == hs_at);
      TFT_VS  = !(vs_at >= 0 && i >= vs_at && i < vs_at + 2);
      Rst     = (rst_at >= 0 && i == rst_at);
      if (vs_at >= 0 && i == vs_at) begin
        if (act && i > 0) close_line(i);
        end_frame();
        act = (i == 0);
      end
      if (rst_at >= 0 && i == rst_at) begin
        // the two pixels still inside the input pipeline are lost
        if (act) repeat (2) void'(exp_q.pop_back());
        act = 1'b0; armed = 1'b0; wbad = 1'b0;
        m_y = 0; m_cnt = 0; last_w = 0;
      end
      if (act) begin
        xi = imin(i, XMAX);
        p  = {c, XW'(xi), YW'(m_y), (xi == 0 && m_y == 0), (i == len - 1)};
        exp_q.push_back(p);
        if (xi == XMAX) wbad = 1'b1;
        if (hs_at >= 1 && (i == hs_at || i == hs_at + 1)) wbad = 1'b1;
      end
    end
    if (act) close_line(len);
    for (int g = 0; g < 5; g++) begin
      @(negedge Clk);
      TFT_DE  = 1'b0;
      TFT_RGB = 16'($urandom);
      TFT_HS  = !(g == 1 || g == 2);
      TFT_VS  = 1'b1;
      Rst     = 1'b0;
    end
  endtask

  task automatic vsync();
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      TFT_DE  = 1'b0;
      TFT_HS  = 1'b1;
      TFT_VS  = !(k == 1 || k == 2);
      TFT_RGB = 16'($urandom);
      Rst     = 1'b0;
      if (k == 1) end_frame();
    end
  endtask

  task automatic frame(input int n, input int short_l = -1, input bit bars = 1'b0);
    for (int l = 0; l < n; l++) line((l == short_l) ? H - 1 : H, -1, -1, -1, bars);
    vsync();
  endtask

  initial begin
    int p0, nl;
    fork
      monitor();
    join_none

    repeat (3) @(negedge Clk);
    check_zero("reset");
    Rst = 1'b0;

    // DE activity before any VS must be ignored
    for (int l = 0; l < 50; l++) line(H + int'($urandom_range(0, 4)) - 2);
    n_cmp++;
    assert (n_pix == 0) else begin n_err++; $error("FAIL pre_vs_pix: got %0d required 0", n_pix); end
    n_cmp++;
    assert (n_fd == 0) else begin n_err++; $error("FAIL pre_vs_fd: got %0d required 0", n_fd); end
    vsync();

    // colour bars, two frames
    p0 = n_pix;
    frame(V, -1, 1'b1);
    n_cmp++;
    assert (n_pix - p0 == H * V) else begin
      n_err++; $error("FAIL frame_pix: got %0d required %0d", n_pix - p0, H * V);
    end
    frame(V, -1, 1'b1);

    frame(V, 3);                                   // one short line
    frame(V - 1);                                  // one line missing
    for (int l = 0; l < V; l++) line((l == 2) ? 70 : H);  // x saturation
    vsync();
    frame(35);                                     // y saturation
    for (int l = 0; l < V; l++) line(H, -1, (l == 4) ? 5 : -1);  // HS inside DE
    vsync();

    // VS mid-line, then a clean frame
    for (int l = 0; l < 3; l++) line(H);
    line(H, H / 2);
    frame(V);

    // VS coinciding with the first DE rise of a frame
    for (int l = 0; l < V; l++) line(H);
    line(H, 0);
    for (int l = 1; l < V; l++) line(H);
    vsync();

    // random frames
    repeat (3) begin
      nl = V - 1 + int'($urandom_range(0, 2));
      for (int l = 0; l < nl; l++)
        line(($urandom_range(0, 3) == 0) ? H - 1 + int'($urandom_range(0, 2)) : H);
      vsync();
    end

    // reset mid-frame, then resync on the next VS
    for (int l = 0; l < 5; l++) line(H);
    line(H, -1, -1, 10);
    for (int l = 6; l < V; l++) line(H);
    vsync();
    frame(V);

    repeat (6) @(negedge Clk);
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_err++; $error("FAIL pix_missing: got %0d pending required 0", exp_q.size());
    end
    n_cmp++;
    assert (rpt_q.size() == 0) else begin
      n_err++; $error("FAIL frame_missing: got %0d pending required 0", rpt_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tft_video_rx.md
Name: tft_video_rx

Overview:
- Receiving end of the 16-bit RGB565 parallel TFT interface (TFT_RGB, TFT_HS, TFT_VS, TFT_DE), in the same pixel-clock domain as the TFT timing controller (9 MHz, 480x272 panel).
- Recovers pixel coordinates from the sync and data-enable stream and emits a pixel stream with frame and line markers.
- Measures active width and height per frame and flags timing errors.
- Used as a loopback checker and as the front end of a capture path into frame memory.

Parameters:
H_ACTIVE, 480, expected active pixels per line (DE-high cycles)
V_ACTIVE, 272, expected active lines per frame (DE-high bursts between VS edges)
XW, 10, width of x counter and pix_x
YW, 10, width of y counter and pix_y
SYNC_ACTIVE_LOW, 1, 1 means HS/VS are asserted low; 0 means asserted high

Ports:
Clk  in  1  pixel clock; all logic on the rising edge
Rst  in  1  synchronous, active-high reset
TFT_RGB  in  16  RGB565 pixel data, valid when TFT_DE=1
TFT_HS  in  1  line sync (polarity per SYNC_ACTIVE_LOW)
TFT_VS  in  1  frame sync (polarity per SYNC_ACTIVE_LOW)
TFT_DE  in  1  data enable, active high
pix_valid  out  1  pixel strobe
pix_data  out  16  pixel value
pix_x  out  XW  column index of the pixel
pix_y  out  YW  row index of the pixel
pix_sof  out  1  pixel is (0,0) of a frame
pix_eol  out  1  pixel is the last of its line
frame_done  out  1  one-cycle pulse at end of a measured frame
meas_width  out  XW  width of the last complete line
meas_height  out  YW  line count of the last complete frame
err_width  out  1  qualified by frame_done: some line in the frame had width != H_ACTIVE
err_height  out  1  qualified by frame_done: meas_height != V_ACTIVE
frame_cnt  out  16  number of completed frames; wraps at 16'hFFFF to 0

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset is sampled on the Clk edge, and a reset asserted mid-frame aborts the frame.
- Input stage: RGB, HS, VS and DE are registered once (stage 1). VS and HS are normalised to active-high (vs_a, hs_a) through SYNC_ACTIVE_LOW. Edge detection compares stage 1 against a stage-2 copy.
- Latency: a pixel sampled with DE=1 on edge N appears with pix_valid=1 after edge N+2. The output is fully registered and there is no backpressure.
- FSM states: IDLE, WAIT_LINE, IN_LINE.
  - IDLE: DE is ignored and no pix_valid is produced. On a vs_a rising edge, go to WAIT_LINE with y=0 and no frame_done.
  - WAIT_LINE: on a DE rising edge, go to IN_LINE with x=0 and emit the first pixel. On a vs_a rising edge, end the frame (see end of frame) and stay in WAIT_LINE.
  - IN_LINE: every DE=1 cycle emits a pixel at (x,y), then x increments. On a DE falling edge, latch meas_width=x, set the sticky w_bad if x!=H_ACTIVE, increment y, and go to WAIT_LINE.
- Markers: pix_sof=1 iff x=0 and y=0. pix_eol is asserted on the last DE=1 cycle of a line, determined from the stage-1 DE lookahead.
- End of frame (vs_a rising edge outside IDLE):
  - frame_done pulses one cycle later.
  - meas_height is set to y.
  - err_height = (y != V_ACTIVE).
  - err_width = w_bad.
  - frame_cnt increments.
  - y and w_bad are then cleared.
- x saturation: x saturates at 2^XW-1, and w_bad is set when it does. pix_x holds the saturated value.
- y saturation: y saturates at 2^YW-1.
- VS mid-line (vs_a rising edge while in IN_LINE): the partial line is closed as on a DE fall, setting w_bad if x!=H_ACTIVE. The frame then ends with that line counted, and the FSM goes to WAIT_LINE.
- HS is used only for the optional consistency check: an HS edge inside DE sets w_bad. Line start is determined by DE alone.
- Simultaneous DE rising edge and vs_a rising edge: the frame ends first, then the pixel is counted at (0,0) of the new frame.

Decomposition:
- Package tft_video_pkg holds:
  - RGB565 colour constants (BLACK 0000, BLUE 001F, RED F800, PURPLE F81F, GREEN 07E0, CYAN 07FF, YELLOW FFE0, WHITE FFFF);
  - the panel defaults H_ACTIVE=480 and V_ACTIVE=272;
  - the FSM state encoding.
- One natural sub-module: tft_sync_edge. It covers the input register, polarity normalisation and rise/fall detection for VS, HS and DE.

Test Plan:
1. Drive TFT_CTRL with the 2x4 colour-bar pattern for two frames. Required response: 130560 pix_valid per frame. (0,0)=0000 with pix_sof=1; (240,68)=F81F; (479,271)=FFFF with pix_eol=1. frame_done at second VS with meas_width=480, meas_height=272, both err=0, frame_cnt=1.
2. Shorten line 100 to 479 DE cycles. Required response: at frame_done, err_width=1, err_height=0, meas_height=272.
3. Send 271 lines between VS edges. Required response: err_height=1, meas_height=271.
4. Toggle DE for 50 lines before the first VS edge. Required response: no pix_valid and no frame_done. The first pix_sof follows the first VS edge.
5. Assert VS at x=200 of line 10. Required response: frame_done with meas_height=11, err_width=1. The next frame starts cleanly at (0,0).
6. Assert Rst for 1 cycle at pixel (300,150), then release. Required response:
   - all outputs are 0 on the next edge;
   - no pix_valid until the next VS edge;
   - the following full frame reports meas_width=480, meas_height=272, no errors.
